// File: rtl/vproc_vregfile_banked.sv
`default_nettype none
// ============================================================================
// Module      : vproc_vregfile_banked
// Description : Banked vector register file. Registers are interleaved over
//               BANK_CNT banks (bank = addr % BANK_CNT), each bank offering one
//               read and one write per cycle. Write conflicts inside a bank go
//               to the lowest-index port. Read conflicts are round-robin.
//               Read data is registered (1-cycle latency) and same-cycle
//               writes are forwarded to reads (write-first). After reset the
//               file clears itself, one row of every bank per cycle.
// Ports       : clk_i, sync_rst_i          clock / synchronous active-high reset
//               wr_valid_i/wr_ready_o      per-port write handshake
//               wr_addr_i/wr_data_i/wr_be_i write address, data, byte enables
//               rd_valid_i/rd_ready_o      per-port read handshake
//               rd_addr_i                  read address
//               rd_rvalid_o/rd_data_o      registered read response
//               init_done_o                zero-initialisation finished
// Revision    : 1.0 - initial release
// ============================================================================
module vproc_vregfile_banked #(
  parameter int unsigned VREG_W      = 512,
  parameter int unsigned VREG_CNT    = 32,
  parameter int unsigned BANK_CNT    = 4,
  parameter int unsigned PORT_RD_CNT = 2,
  parameter int unsigned PORT_WR_CNT = 2
) (
  input  logic                                           clk_i,
  input  logic                                           sync_rst_i,
  input  logic [PORT_WR_CNT-1:0]                         wr_valid_i,
  output logic [PORT_WR_CNT-1:0]                         wr_ready_o,
  input  logic [PORT_WR_CNT-1:0][$clog2(VREG_CNT)-1:0]   wr_addr_i,
  input  logic [PORT_WR_CNT-1:0][VREG_W-1:0]             wr_data_i,
  input  logic [PORT_WR_CNT-1:0][VREG_W/8-1:0]           wr_be_i,
  input  logic [PORT_RD_CNT-1:0]                         rd_valid_i,
  output logic [PORT_RD_CNT-1:0]                         rd_ready_o,
  input  logic [PORT_RD_CNT-1:0][$clog2(VREG_CNT)-1:0]   rd_addr_i,
  output logic [PORT_RD_CNT-1:0]                         rd_rvalid_o,
  output logic [PORT_RD_CNT-1:0][VREG_W-1:0]             rd_data_o,
  output logic                                           init_done_o
);

  localparam int unsigned ADDR_W = $clog2(VREG_CNT);
  localparam int unsigned ROWS   = VREG_CNT / BANK_CNT;
  localparam int unsigned CNT_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned RR_W   = (PORT_RD_CNT > 1) ? $clog2(PORT_RD_CNT) : 1;

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                                state_q, state_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic [BANK_CNT-1:0][RR_W-1:0]         rr_q, rr_d;
  logic [PORT_RD_CNT-1:0]                rvalid_q;
  logic [PORT_RD_CNT-1:0][VREG_W-1:0]    rdata_q;
  logic [VREG_W-1:0]                     mem_q [VREG_CNT];

  logic                                  run;
  logic [PORT_WR_CNT-1:0]                wr_acc;
  logic [PORT_RD_CNT-1:0]                rd_acc;
  logic [PORT_RD_CNT-1:0][VREG_W-1:0]    rd_val;

  // BANK_CNT is a power of two, so the bank index is the low address bits.
  function automatic logic [ADDR_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
    return a & ADDR_W'(BANK_CNT - 1);
  endfunction

  function automatic logic [VREG_W-1:0] merge(input logic [VREG_W-1:0]   old_v,
                                              input logic [VREG_W-1:0]   new_v,
                                              input logic [VREG_W/8-1:0] be);
    logic [VREG_W-1:0] res;
    res = old_v;
    for (int i = 0; i < int'(VREG_W / 8); i++) begin
      if (be[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return res;
  endfunction

  // Init / run control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run     = 1'b0;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ROWS - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN:  run = 1'b1;
      default: state_d = ST_INIT;
    endcase
  end

  // Write arbitration: a port is blocked by any lower-index valid port aimed
  // at the same bank. A port's own valid is not used, so no valid->ready path.
  always_comb begin
    logic blocked;
    wr_ready_o = '0;
    blocked    = 1'b0;
    for (int p = 0; p < int'(PORT_WR_CNT); p++) begin
      blocked = 1'b0;
      for (int q = 0; q < p; q++) begin
        if (wr_valid_i[q] && (bank_of(wr_addr_i[q]) == bank_of(wr_addr_i[p]))) blocked = 1'b1;
      end
      wr_ready_o[p] = run && !blocked;
    end
  end

  assign wr_acc = wr_valid_i & wr_ready_o;

  // Read arbitration: per bank, cyclic search starting at the RR pointer.
  always_comb begin
    logic found;
    int   idx;
    rd_ready_o = '0;
    rr_d       = rr_q;
    found      = 1'b0;
    idx        = 0;
    for (int b = 0; b < int'(BANK_CNT); b++) begin
      found = 1'b0;
      for (int k = 0; k < int'(PORT_RD_CNT); k++) begin
        idx = (int'(rr_q[b]) + k) % int'(PORT_RD_CNT);
        if (!found && rd_valid_i[idx] && (int'(bank_of(rd_addr_i[idx])) == b)) begin
          found           = 1'b1;
          rd_ready_o[idx] = run;
          if (run) rr_d[b] = RR_W'((idx + 1) % int'(PORT_RD_CNT));
        end
      end
    end
  end

  assign rd_acc = rd_valid_i & rd_ready_o;

  // Write-first forwarding: at most one accepted write per bank, so at most
  // one write can match a given read address.
  always_comb begin
    for (int p = 0; p < int'(PORT_RD_CNT); p++) begin
      rd_val[p] = mem_q[rd_addr_i[p]];
      for (int w = 0; w < int'(PORT_WR_CNT); w++) begin
        if (wr_acc[w] && (wr_addr_i[w] == rd_addr_i[p]))
          rd_val[p] = merge(rd_val[p], wr_data_i[w], wr_be_i[w]);
      end
    end
  end

  // Storage carries no reset; INIT clears it row by row after every reset.
  always_ff @(posedge clk_i) begin
    if (!sync_rst_i) begin
      if (state_q == ST_INIT) begin
        for (int b = 0; b < int'(BANK_CNT); b++)
          mem_q[ADDR_W'(int'(cnt_q) * int'(BANK_CNT) + b)] <= '0;
      end else begin
        for (int w = 0; w < int'(PORT_WR_CNT); w++) begin
          if (wr_acc[w])
            mem_q[wr_addr_i[w]] <= merge(mem_q[wr_addr_i[w]], wr_data_i[w], wr_be_i[w]);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      rr_q     <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      rvalid_q <= rd_acc;
      for (int p = 0; p < int'(PORT_RD_CNT); p++) begin
        if (rd_acc[p]) rdata_q[p] <= rd_val[p];
      end
    end
  end

  assign rd_rvalid_o = rvalid_q;
  assign rd_data_o   = rdata_q;
  assign init_done_o = (state_q == ST_RUN);

  generate
    for (genvar p = 0; p < PORT_WR_CNT; p++) begin : g_wr_addr_chk
      a_wr_addr: assert property (@(posedge clk_i) disable iff (sync_rst_i)
                                  wr_valid_i[p] |-> (int'(wr_addr_i[p]) < int'(VREG_CNT)));
    end
    for (genvar p = 0; p < PORT_RD_CNT; p++) begin : g_rd_addr_chk
      a_rd_addr: assert property (@(posedge clk_i) disable iff (sync_rst_i)
                                  rd_valid_i[p] |-> (int'(rd_addr_i[p]) < int'(VREG_CNT)));
    end
  endgenerate

endmodule
`default_nettype wire
